// File: rtl/instr_mem_pkg.sv
// instr_mem_pkg: shared FSM state encoding and counter limit for the instruction memory responder.
package instr_mem_pkg;

    typedef enum logic [1:0] {IDLE, READ, HOLD, RESP} instr_mem_state_t;

    localparam logic [31:0] SERVED_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/memory_read_iface.sv
// memory_read_iface: single-word instruction fetch request/response bundle with fill broadcast.
interface memory_read_iface #(
    parameter int MEMORY_WIDTH      = 16,
    parameter int MEMORY_ADDR_WIDTH = 11
);

    logic [MEMORY_ADDR_WIDTH-1:0] addr;
    logic                         valid;
    logic                         ready;
    logic [MEMORY_WIDTH-1:0]      data;
    logic [MEMORY_ADDR_WIDTH-1:0] broadcast_addr;
    logic                         broadcast_valid;

    modport in (
        input  addr, valid,
        output ready, data, broadcast_addr, broadcast_valid
    );

endinterface

// File: rtl/instr_ram_1r1w.sv
// instr_ram_1r1w: synchronous read-first simple dual-port RAM
module instr_ram_1r1w #(
  parameter int W = 16,
  parameter int AW = 11,
  parameter INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data
);
  logic [W-1:0] mem_q [2**AW];
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem_q[rd_addr];
  end
endmodule

// File: rtl/instr_memory_responder.sv
// instr_memory_responder: serves instruction fetches from on-chip RAM; INSTR_MEM_OUTREG_EN adds an output register stage.
module instr_memory_responder
    import instr_mem_pkg::*;
#(
    parameter int MEMORY_WIDTH      = 16,
    parameter int MEMORY_ADDR_WIDTH = 11,
    parameter     INIT_FILE         = ""
) (
    input  logic                         clk,
    input  logic                         rst,
    memory_read_iface.in                 memory,
    input  logic                         wr_en,
    input  logic [MEMORY_ADDR_WIDTH-1:0] wr_addr,
    input  logic [MEMORY_WIDTH-1:0]      wr_data,
    output logic [31:0]                  served_count,
    output logic                         busy
);

    instr_mem_state_t             state_q, state_d;
    logic [MEMORY_ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [MEMORY_ADDR_WIDTH-1:0] bcast_addr_q, bcast_addr_d;
    logic [MEMORY_WIDTH-1:0]      data_q, data_d;
    logic [31:0]                  served_count_q, served_count_d;
    logic                         skip_q, skip_d;
    logic                         accept;
    logic                         load;
    logic [MEMORY_WIDTH-1:0]      rd_data;
    logic [MEMORY_WIDTH-1:0]      resp_word;

    instr_ram_1r1w #(
        .W         (MEMORY_WIDTH),
        .AW        (MEMORY_ADDR_WIDTH),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk     (clk),
        .rd_en   (accept),
        .rd_addr (memory.addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

`ifdef INSTR_MEM_OUTREG_EN
    logic [MEMORY_WIDTH-1:0] outreg_q, outreg_d;

    // Output register captures the RAM word while in READ.
    always_comb outreg_d = (state_q == READ) ? rd_data : outreg_q;

    // Output register stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) outreg_q <= '0;
        else      outreg_q <= outreg_d;
    end

    assign resp_word = outreg_q;
`else
    assign resp_word = rd_data;
`endif

    // Next-state logic; response registers load on the transition into RESP.
    always_comb begin
        state_d        = state_q;
        req_addr_d     = req_addr_q;
        bcast_addr_d   = bcast_addr_q;
        data_d         = data_q;
        served_count_d = served_count_q;
        skip_d         = 1'b0;
        accept         = 1'b0;
        load           = 1'b0;
        case (state_q)
            IDLE: begin
                if (memory.valid && !skip_q) begin
                    accept     = 1'b1;
                    req_addr_d = memory.addr;
                    state_d    = READ;
                end
            end
`ifdef INSTR_MEM_OUTREG_EN
            READ: state_d = HOLD;
            HOLD: begin
                load    = 1'b1;
                state_d = RESP;
            end
`else
            READ: begin
                load    = 1'b1;
                state_d = RESP;
            end
`endif
            RESP: begin
                skip_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            data_d         = resp_word;
            bcast_addr_d   = req_addr_q;
            served_count_d = (served_count_q == SERVED_MAX) ? served_count_q : served_count_q + 32'd1;
        end
    end

    // State and response registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            req_addr_q     <= '0;
            bcast_addr_q   <= '0;
            data_q         <= '0;
            served_count_q <= '0;
            skip_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            req_addr_q     <= req_addr_d;
            bcast_addr_q   <= bcast_addr_d;
            data_q         <= data_d;
            served_count_q <= served_count_d;
            skip_q         <= skip_d;
        end
    end

    assign memory.ready           = (state_q == RESP);
    assign memory.broadcast_valid = (state_q == RESP);
    assign memory.data            = data_q;
    assign memory.broadcast_addr  = bcast_addr_q;
    assign served_count           = served_count_q;
    assign busy                   = (state_q != IDLE);

endmodule
